aes_key_schedule: RTL and testbench

- Iterative AES-128 key expansion engine.
- Takes a 128-bit cipher key and emits round keys 0..10 one at a time over a valid/ready handshake.
- Feeds the AddRoundKey stage that consumes the transformColumns (MixColumns) output in each round.
- Computes one new round key per accepted transfer, so the cipher datapath never stores all 11 keys.

---
 rtl/aes_key_schedule_if.sv | 22 ++
 rtl/aes_key_schedule.sv | 132 +++++++++++++
 tb/tb_aes_key_schedule.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_schedule_if.sv
// Handshake and data bundle between the AES-128 key schedule and its driver/consumer.
// master drives start/key_in/rk_ready; slave (the schedule) returns the round keys.
interface aes_key_schedule_if;
    logic             start;
    logic [15:0][7:0] key_in;
    logic             rk_ready;
    logic             rk_valid;
    logic [3:0]       rk_index;
    logic [15:0][7:0] round_key;
    logic             busy;
    logic             done;

    modport master (
        output start, key_in, rk_ready,
        input  rk_valid, rk_index, round_key, busy, done
    );

    modport slave (
        input  start, key_in, rk_ready,
        output rk_valid, rk_index, round_key, busy, done
    );
endinterface

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one round key per valid/ready transfer, first key 1 cycle after start.
// A stalled consumer (rk_ready=0) freezes round_key, rk_index and Rcon for as long as it likes.
module aes_key_schedule #(
    parameter int NR = 10
) (
    input  logic              clk,
    input  logic              reset,
    aes_key_schedule_if.slave ks
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    // FIPS-197 S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sub_byte(x[31:24]), sub_byte(x[23:16]), sub_byte(x[15:8]), sub_byte(x[7:0])};
    endfunction

    // Lowest-addressed byte of a word sits in bits [7:0] of the bus but is the MSB in FIPS order.
    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t           state_q, state_d;
    logic [15:0][7:0] round_key_q, round_key_d;
    logic [3:0]       rk_index_q, rk_index_d;
    logic [7:0]       rcon_q, rcon_d;
    logic             done_q, done_d;

    logic [127:0]     rk_flat;
    logic [31:0]      w0, w1, w2, w3;
    logic [31:0]      t_w;
    logic [31:0]      nw0, nw1, nw2, nw3;
    logic [15:0][7:0] next_key;

    assign rk_flat = round_key_q;
    assign w0 = bswap32(rk_flat[31:0]);
    assign w1 = bswap32(rk_flat[63:32]);
    assign w2 = bswap32(rk_flat[95:64]);
    assign w3 = bswap32(rk_flat[127:96]);

    // RotWord, SubWord and Rcon, then the XOR ripple across the four words in one cycle.
    assign t_w = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_q, 24'h000000};
    assign nw0 = w0 ^ t_w;
    assign nw1 = w1 ^ nw0;
    assign nw2 = w2 ^ nw1;
    assign nw3 = w3 ^ nw2;
    assign next_key = {bswap32(nw3), bswap32(nw2), bswap32(nw1), bswap32(nw0)};

    always_comb begin
        state_d     = state_q;
        round_key_d = round_key_q;
        rk_index_d  = rk_index_q;
        rcon_d      = rcon_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ks.start) begin
                    state_d     = EXPAND;
                    round_key_d = ks.key_in;
                    rk_index_d  = 4'd0;
                    rcon_d      = 8'h01;
                end
            end
            EXPAND: begin
                if (ks.rk_ready) begin
                    if (rk_index_q == 4'(NR)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        round_key_d = next_key;
                        rk_index_d  = rk_index_q + 4'd1;
                        rcon_d      = xtime(rcon_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            round_key_q <= '0;
            rk_index_q  <= 4'd0;
            rcon_q      <= 8'h01;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_key_q <= round_key_d;
            rk_index_q  <= rk_index_d;
            rcon_q      <= rcon_d;
            done_q      <= done_d;
        end
    end

    assign ks.rk_valid  = (state_q == EXPAND);
    assign ks.busy      = (state_q != IDLE);
    assign ks.done      = done_q;
    assign ks.rk_index  = rk_index_q;
    assign ks.round_key = round_key_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule using the FIPS-197 appendix key expansions.
module tb_aes_key_schedule;

    logic clk;
    logic reset;

    aes_key_schedule_if ks_if();

    aes_key_schedule dut (
        .clk   (clk),
        .reset (reset),
        .ks    (ks_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Round keys in FIPS byte order (byte 0 leftmost).
    logic [127:0] k1_rk [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    logic [127:0] k2_rk [0:10] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    exp_t sb[$];
    logic done_pend;
    int   n_checks;
    int   n_pass;
    int   ready_mode;
    int   stall_cnt;

    // Bus byte i occupies bits [8i+7:8i]; FIPS byte i is the i-th byte from the left of the hex string.
    function automatic logic [127:0] fips(input logic [127:0] h);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = h[127-8*i -: 8];
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic push_seq(input int which);
        exp_t e;
        for (int i = 0; i <= 10; i++) begin
            e.idx = 4'(i);
            e.key = fips(which == 1 ? k2_rk[i] : k1_rk[i]);
            sb.push_back(e);
        end
    endtask

    task automatic start_key(input int which);
        @(posedge clk); #2;
        ks_if.start  = 1'b1;
        ks_if.key_in = fips(which == 1 ? k2_rk[0] : k1_rk[0]);
        @(posedge clk); #1;
        push_seq(which);
        ks_if.start  = 1'b0;
        ks_if.key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk); #1;
            if (sb.size() == 0 && !ks_if.busy) ok = 1'b1;
        end
        if (!ok) check_eq("idle_timeout_sb", 128'(sb.size()), 128'd0);
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_done_then_start(input int which);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < 400 && !hit; c++) begin
            @(posedge clk); #2;
            if (ks_if.done) begin
                hit = 1'b1;
                ks_if.start  = 1'b1;
                ks_if.key_in = fips(which == 1 ? k2_rk[0] : k1_rk[0]);
                @(posedge clk); #1;
                push_seq(which);
                ks_if.start  = 1'b0;
            end
        end
        if (!hit) check_eq("done_timeout", 128'(ks_if.done), 128'd1);
    endtask

    // Consumer: always ready, or pseudo-random with a forced 5-cycle stall at index 3.
    initial begin
        ks_if.rk_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            if (ready_mode == 0) begin
                ks_if.rk_ready = 1'b1;
            end else if (ks_if.rk_valid && ks_if.rk_index == 4'd3 && stall_cnt < 5) begin
                ks_if.rk_ready = 1'b0;
                stall_cnt++;
            end else begin
                ks_if.rk_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Output monitor: compares every presented key against the scoreboard head.
    initial begin
        exp_t e;
        bit   exp_valid;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_valid = (sb.size() != 0);
                check_eq("rk_valid", 128'(ks_if.rk_valid), 128'(exp_valid));
                check_eq("busy", 128'(ks_if.busy), 128'(exp_valid));
                check_eq("done", 128'(ks_if.done), 128'(done_pend));
                done_pend = 1'b0;
                if (ks_if.rk_valid && sb.size() != 0) begin
                    e = sb[0];
                    check_eq($sformatf("rk_index_%0d", e.idx), 128'(ks_if.rk_index), 128'(e.idx));
                    check_eq($sformatf("round_key_%0d", e.idx), ks_if.round_key, e.key);
                    if (ks_if.rk_ready) begin
                        void'(sb.pop_front());
                        if (e.idx == 4'd10) done_pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        done_pend    = 1'b0;
        ready_mode   = 0;
        stall_cnt    = 0;
        reset        = 1'b1;
        ks_if.start  = 1'b0;
        ks_if.key_in = '0;
        #3;
        check_eq("rst_valid", 128'(ks_if.rk_valid), 128'd0);
        check_eq("rst_index", 128'(ks_if.rk_index), 128'd0);
        check_eq("rst_key", ks_if.round_key, 128'd0);
        check_eq("rst_busy", 128'(ks_if.busy), 128'd0);
        check_eq("rst_done", 128'(ks_if.done), 128'd0);
        @(posedge clk); #2;
        reset = 1'b0;

        // Back-to-back transfers with rk_ready held high.
        start_key(0);
        wait_idle();

        // Random backpressure plus a start attempt while busy at index 4.
        ready_mode = 1;
        stall_cnt  = 0;
        start_key(0);
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 400 && !seen; c++) begin
                @(posedge clk); #2;
                if (ks_if.rk_valid && ks_if.rk_index == 4'd4) seen = 1'b1;
            end
            if (!seen) check_eq("idx4_timeout", 128'(ks_if.rk_index), 128'd4);
            ks_if.start  = 1'b1;
            ks_if.key_in = fips(k2_rk[0]);
            @(posedge clk); #2;
            ks_if.start  = 1'b0;
        end
        wait_idle();
        ready_mode = 0;

        // Asynchronous reset in the middle of index 6.
        start_key(0);
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 400 && !seen; c++) begin
                @(negedge clk);
                if (ks_if.rk_valid && ks_if.rk_index == 4'd6) seen = 1'b1;
            end
            if (!seen) check_eq("idx6_timeout", 128'(ks_if.rk_index), 128'd6);
        end
        #2;
        reset = 1'b1;
        #1;
        sb.delete();
        done_pend = 1'b0;
        check_eq("mid_rst_valid", 128'(ks_if.rk_valid), 128'd0);
        check_eq("mid_rst_index", 128'(ks_if.rk_index), 128'd0);
        check_eq("mid_rst_key", ks_if.round_key, 128'd0);
        check_eq("mid_rst_busy", 128'(ks_if.busy), 128'd0);
        check_eq("mid_rst_done", 128'(ks_if.done), 128'd0);
        @(posedge clk); #2;
        reset = 1'b0;

        // Restart after reset, then start the second key in the done cycle.
        start_key(0);
        wait_done_then_start(1);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
